// File: rtl/serial_sub_ctrl.sv
// serial_sub_ctrl: bit-serial subtraction controller.
// Sequences a single 1-bit subtract cell (two half subtractors plus a borrow OR)
// over a WIDTH-bit operand pair, LSB first, and returns a - b with the final
// borrow after WIDTH RUN cycles. Handshakes: req_valid_i/req_ready_o on the
// request side and res_valid_o/res_ready_i on the result side.
// Optional feature: define ZERO_FLAG_EN to add the registered zero_o flag.
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             busy_o,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [WIDTH-1:0] diff_o,
    output logic             borrow_o
`ifdef ZERO_FLAG_EN
    ,
    output logic             zero_o
`endif
);

    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             bin_q, bin_d;

    // Presented result lives in its own registers so diff_o/borrow_o stay
    // put while the next operation shifts and clears the working registers.
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
`ifdef ZERO_FLAG_EN
    logic             zero_q, zero_d;
`endif

    // One-bit subtract cell and the result word as it will look after this bit.
    logic             a0, b0, d1, br1, d_bit, br2, bout;
    logic [WIDTH-1:0] res_shift;

    // Datapath: the shared single-bit subtract cell fed by the operand LSBs.
    always_comb begin
        a0        = a_q[0];
        b0        = b_q[0];
        d1        = a0 ^ b0;
        br1       = ~a0 & b0;
        d_bit     = d1 ^ bin_q;
        br2       = ~d1 & bin_q;
        bout      = br1 | br2;
        res_shift = {d_bit, res_q[WIDTH-1:1]};
    end

    // Next-state logic for the IDLE -> RUN -> DONE sequence.
    always_comb begin
        // NOTE: every signal gets a hold default first so no path leaves it unassigned (no latch).
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        bin_d    = bin_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
`ifdef ZERO_FLAG_EN
        zero_d   = zero_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    a_d     = a_i;
                    b_d     = b_i;
                    bin_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end

            S_RUN: begin
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                res_d = res_shift;
                bin_d = bout;
                if (cnt_q == LAST_BIT) begin
                    // Last bit: publish the finished word; the counter is left
                    // at WIDTH-1 so it never wraps.
                    diff_d   = res_shift;
                    borrow_d = bout;
`ifdef ZERO_FLAG_EN
                    zero_d   = (res_shift == '0);
`endif
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_DONE: begin
                if (res_ready_i) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset; reset wins over any handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            bin_q    <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
`ifdef ZERO_FLAG_EN
            zero_q   <= 1'b1;
`endif
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            bin_q    <= bin_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
`ifdef ZERO_FLAG_EN
            zero_q   <= zero_d;
`endif
        end
    end

    // Outputs decode only registered state; no input reaches an output combinationally.
    assign req_ready_o = (state_q == S_IDLE);
    assign busy_o      = (state_q == S_RUN);
    assign res_valid_o = (state_q == S_DONE);
    assign diff_o      = diff_q;
    assign borrow_o    = borrow_q;
`ifdef ZERO_FLAG_EN
    assign zero_o      = zero_q;
`endif

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// tb_serial_sub_ctrl: self-checking bench for serial_sub_ctrl.
// Instances at WIDTH=8 (directed vectors and corner sequences plus random
// sweep) and WIDTH=3 (random sweep). Expected results come from a table or an
// arithmetic reference model and flow through a scoreboard queue.
module tb_serial_sub_ctrl;

    typedef struct {
        logic [31:0] diff;
        logic        borrow;
        logic        zero;
    } exp_t;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] diff;
        logic       borrow;
        logic       zero;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    // WIDTH=8 instance signals
    logic       req_valid8, req_ready8, busy8, res_valid8, res_ready8, borrow8;
    logic [7:0] a8, b8, diff8;
    // WIDTH=3 instance signals
    logic       req_valid3, req_ready3, busy3, res_valid3, res_ready3, borrow3;
    logic [2:0] a3, b3, diff3;
`ifdef ZERO_FLAG_EN
    logic       zero8, zero3;
`endif

    serial_sub_ctrl #(.WIDTH(8)) dut8 (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid8),
        .req_ready_o (req_ready8),
        .a_i         (a8),
        .b_i         (b8),
        .busy_o      (busy8),
        .res_valid_o (res_valid8),
        .res_ready_i (res_ready8),
        .diff_o      (diff8),
        .borrow_o    (borrow8)
`ifdef ZERO_FLAG_EN
        ,
        .zero_o      (zero8)
`endif
    );

    serial_sub_ctrl #(.WIDTH(3)) dut3 (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid3),
        .req_ready_o (req_ready3),
        .a_i         (a3),
        .b_i         (b3),
        .busy_o      (busy3),
        .res_valid_o (res_valid3),
        .res_ready_i (res_ready3),
        .diff_o      (diff3),
        .borrow_o    (borrow3)
`ifdef ZERO_FLAG_EN
        ,
        .zero_o      (zero3)
`endif
    );

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb8[$];
    exp_t sb3[$];
    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: actual=0x%0h required=0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock and sample/drive 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Arithmetic reference: (a - b) mod 2^w, borrow when a < b unsigned.
    function automatic exp_t model(input int w, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        logic [31:0] mask;
        mask     = (32'd1 << w) - 32'd1;
        e.diff   = (a - b) & mask;
        e.borrow = (a < b);
        e.zero   = (e.diff == 32'd0);
        return e;
    endfunction

    function automatic exp_t vec_exp(input vec_t v);
        exp_t e;
        e.diff   = {24'd0, v.diff};
        e.borrow = v.borrow;
        e.zero   = v.zero;
        return e;
    endfunction

    // Present a request on dut8, wait (bounded) for acceptance, push expectation.
    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input exp_t e);
        int guard = 0;
        a8         = a;
        b8         = b;
        req_valid8 = 1'b1;
        while (!req_ready8 && guard < 50) begin
            tick();
            guard++;
        end
        check("issue8_ready_seen", req_ready8, 1);
        tick();
        req_valid8 = 1'b0;
        sb8.push_back(e);
        check("accept_busy", busy8, 1);
        check("accept_ready_low", req_ready8, 0);
    endtask

    // Wait (bounded) for dut8 result, check latency, pop and compare.
    task automatic wait_result8(input string tag);
        int   cyc = 0;
        exp_t e;
        while (!res_valid8 && cyc < 100) begin
            tick();
            cyc++;
        end
        check({tag, "_latency"}, cyc, 8);
        if (sb8.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s_scoreboard: result with no expectation queued", tag);
        end else begin
            e = sb8.pop_front();
            check({tag, "_diff"}, diff8, e.diff);
            check({tag, "_borrow"}, borrow8, e.borrow);
`ifdef ZERO_FLAG_EN
            check({tag, "_zero"}, zero8, e.zero);
`endif
        end
    endtask

    task automatic consume8(input string tag);
        res_ready8 = 1'b1;
        tick();
        res_ready8 = 1'b0;
        check({tag, "_ready_after_consume"}, req_ready8, 1);
        check({tag, "_valid_after_consume"}, res_valid8, 0);
    endtask

    // Random sweep on dut8 with both handshakes tied high.
    task automatic sweep8(input int n);
        int   issued = 0, got = 0, cyc = 0, last = -1;
        bit   acc = 1'b0;
        exp_t e;
        res_ready8 = 1'b1;
        a8         = 8'($urandom);
        b8         = 8'($urandom);
        req_valid8 = 1'b1;
        while (got < n && cyc < n * 20) begin
            if (res_valid8) begin
                if (sb8.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sweep8_scoreboard: unexpected result at cycle %0d", cyc);
                end else begin
                    e = sb8.pop_front();
                    check("sweep8_diff", diff8, e.diff);
                    check("sweep8_borrow", borrow8, e.borrow);
`ifdef ZERO_FLAG_EN
                    check("sweep8_zero", zero8, e.zero);
`endif
                end
                if (last >= 0) check("sweep8_spacing", cyc - last, 10);
                last = cyc;
                got++;
            end
            if (acc) begin
                acc = 1'b0;
                if (issued == n) begin
                    req_valid8 = 1'b0;
                end else begin
                    a8 = 8'($urandom);
                    b8 = 8'($urandom);
                end
            end
            if (req_ready8 && req_valid8 && issued < n) begin
                sb8.push_back(model(8, {24'd0, a8}, {24'd0, b8}));
                issued++;
                acc = 1'b1;
            end
            tick();
            cyc++;
        end
        check("sweep8_result_count", got, n);
        res_ready8 = 1'b0;
        req_valid8 = 1'b0;
    endtask

    // Random sweep on dut3 with both handshakes tied high.
    task automatic sweep3(input int n);
        int   issued = 0, got = 0, cyc = 0, last = -1;
        bit   acc = 1'b0;
        exp_t e;
        res_ready3 = 1'b1;
        a3         = 3'($urandom);
        b3         = 3'($urandom);
        req_valid3 = 1'b1;
        while (got < n && cyc < n * 20) begin
            if (res_valid3) begin
                if (sb3.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sweep3_scoreboard: unexpected result at cycle %0d", cyc);
                end else begin
                    e = sb3.pop_front();
                    check("sweep3_diff", diff3, e.diff);
                    check("sweep3_borrow", borrow3, e.borrow);
`ifdef ZERO_FLAG_EN
                    check("sweep3_zero", zero3, e.zero);
`endif
                end
                if (last >= 0) check("sweep3_spacing", cyc - last, 5);
                last = cyc;
                got++;
            end
            if (acc) begin
                acc = 1'b0;
                if (issued == n) begin
                    req_valid3 = 1'b0;
                end else begin
                    a3 = 3'($urandom);
                    b3 = 3'($urandom);
                end
            end
            if (req_ready3 && req_valid3 && issued < n) begin
                sb3.push_back(model(3, {29'd0, a3}, {29'd0, b3}));
                issued++;
                acc = 1'b1;
            end
            tick();
            cyc++;
        end
        check("sweep3_result_count", got, n);
        res_ready3 = 1'b0;
        req_valid3 = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        req_valid8 = 1'b0; res_ready8 = 1'b0; a8 = '0; b8 = '0;
        req_valid3 = 1'b0; res_ready3 = 1'b0; a3 = '0; b3 = '0;

        //           a      b      diff   borrow zero
        vecs[0] = '{8'h5A, 8'h3C, 8'h1E, 1'b0, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 8'hFF, 1'b1, 1'b0};
        vecs[2] = '{8'hFF, 8'hFF, 8'h00, 1'b0, 1'b1};
        vecs[3] = '{8'h10, 8'h01, 8'h0F, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 8'h7F, 8'h01, 1'b0, 1'b0};
        vecs[5] = '{8'h7F, 8'h80, 8'hFF, 1'b1, 1'b0};
        vecs[6] = '{8'h01, 8'hFF, 8'h02, 1'b1, 1'b0};
        vecs[7] = '{8'h00, 8'h00, 8'h00, 1'b0, 1'b1};

        tick();
        tick();
        rst = 1'b0;

        // Reset values
        check("rst_ready8", req_ready8, 1);
        check("rst_busy8", busy8, 0);
        check("rst_valid8", res_valid8, 0);
        check("rst_diff8", diff8, 0);
        check("rst_borrow8", borrow8, 0);
        check("rst_ready3", req_ready3, 1);
        check("rst_valid3", res_valid3, 0);
`ifdef ZERO_FLAG_EN
        check("rst_zero8", zero8, 1);
`endif

        // Table-driven vectors
        for (int i = 0; i < 8; i++) begin
            issue8(vecs[i].a, vecs[i].b, vec_exp(vecs[i]));
            wait_result8($sformatf("vec%0d", i));
            consume8($sformatf("vec%0d", i));
        end

        // Backpressure: result held 5 cycles while a new request is pending
        issue8(8'h33, 8'h11, model(8, 32'h33, 32'h11));
        wait_result8("bp");
        a8 = 8'h99; b8 = 8'h11; req_valid8 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("bp_valid_held", res_valid8, 1);
            check("bp_ready_low", req_ready8, 0);
            check("bp_diff_stable", diff8, 8'h22);
            check("bp_busy_low", busy8, 0);
        end
        res_ready8 = 1'b1; req_valid8 = 1'b0;
        tick();
        res_ready8 = 1'b0;
        check("bp_idle_ready", req_ready8, 1);
        check("bp_idle_valid", res_valid8, 0);
        check("bp_diff_kept", diff8, 8'h22);
        tick();
        check("bp_not_accepted", busy8, 0);

        // Reset pulsed mid-RUN discards the partial operation
        issue8(8'hAA, 8'h55, model(8, 32'hAA, 32'h55));
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb8.delete();
        check("abort_ready", req_ready8, 1);
        check("abort_valid", res_valid8, 0);
        check("abort_busy", busy8, 0);
        check("abort_diff_cleared", diff8, 0);
        issue8(8'h10, 8'h01, model(8, 32'h10, 32'h01));
        wait_result8("after_abort");
        consume8("after_abort");

        // Reset and request on the same edge: reset wins
        a8 = 8'h44; b8 = 8'h22; req_valid8 = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; req_valid8 = 1'b0;
        check("rst_vs_req_busy", busy8, 0);
        check("rst_vs_req_ready", req_ready8, 1);

        // Operands changing during RUN do not affect the result
        issue8(8'h5A, 8'h3C, model(8, 32'h5A, 32'h3C));
        a8 = 8'hFF; b8 = 8'h00; req_valid8 = 1'b1;
        wait_result8("opchg");
        req_valid8 = 1'b0;
        consume8("opchg");

        // Reset and res_ready together in DONE clear the outputs
        issue8(8'h01, 8'h02, model(8, 32'h01, 32'h02));
        wait_result8("rst_done");
        res_ready8 = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; res_ready8 = 1'b0;
        check("rst_done_valid", res_valid8, 0);
        check("rst_done_ready", req_ready8, 1);
        check("rst_done_diff", diff8, 0);
        check("rst_done_borrow", borrow8, 0);
`ifdef ZERO_FLAG_EN
        check("rst_done_zero", zero8, 1);
`endif

        // Random sweeps with handshakes tied high
        sweep8(1000);
        sweep3(1000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/serial_sub_ctrl.md
# serial_sub_ctrl

Bit-serial subtraction controller. It sequences one 1-bit subtract cell (two half subtractors plus borrow OR) over a WIDTH-bit operand pair, LSB first, and returns a - b with the final borrow. It sits between a requester issuing operand pairs and the shared single-bit subtract datapath. This trades WIDTH cycles of latency for a one-bit-wide datapath.

## Interface
Parameters:
- WIDTH, default 8, operand and result width in bits; legal range 2..32.

Ports:
- clk_i  input  1  single clock; all state updates on its rising edge.
- rst_i  input  1  reset, synchronous, active-high.
- req_valid_i  input  1  operand pair present on a_i/b_i.
- req_ready_o  output  1  controller can accept a request (state IDLE).
- a_i  input  WIDTH  minuend; sampled only on the acceptance edge.
- b_i  input  WIDTH  subtrahend; sampled only on the acceptance edge.
- busy_o  output  1  high in RUN.
- res_valid_o  output  1  result valid (state DONE).
- res_ready_i  input  1  consumer takes the result.
- diff_o  output  WIDTH  (a - b) mod 2^WIDTH.
- borrow_o  output  1  final borrow; 1 exactly when a < b unsigned.
- zero_o  output  1  present only with ZERO_FLAG_EN; result equals 0.

## Operation
- States: IDLE, RUN, DONE. State is encoded in registers. Outputs are decoded from state and registers, with no combinational path from any input to any output.
- IDLE: req_ready_o=1.
  - On req_valid_i=1 at an edge: load a_i and b_i into shift registers, clear the borrow register and the bit counter, and go to RUN.
  - Otherwise stay in IDLE.
- RUN: one bit per cycle, using the current LSBs a0 and b0 and the borrow register bin.
  - First half subtractor: d1 = a0^b0, br1 = ~a0&b0.
  - Second half subtractor: d = d1^bin, br2 = ~d1&bin.
  - Borrow out: bout = br1|br2.
  - d is shifted into the result register from the MSB end. The operand registers shift right. The borrow register takes bout. The counter increments.
  - When the counter equals WIDTH-1, the current edge performs the last bit and the state goes to DONE.
  - Counter width is $clog2(WIDTH). It never wraps, because exit happens at WIDTH-1.
- DONE: res_valid_o=1. diff_o, borrow_o and zero_o are held stable.
  - On res_ready_i=1 go to IDLE. Otherwise hold indefinitely.
- req_valid_i is ignored outside IDLE. No request is queued. The requester must hold req_valid_i until it sees req_ready_o.
- res_ready_i is ignored outside DONE.
- diff_o and borrow_o keep their last result after leaving DONE, until the next result overwrites them. They are only meaningful while res_valid_o=1.
- Reset, at any state including mid-RUN: next state is IDLE; counter, borrow, operand and result registers are cleared. A partial result is discarded and never presented.

## Timing
- Reset values: req_ready_o=1, busy_o=0, res_valid_o=0, diff_o=0, borrow_o=0, zero_o=1 when ZERO_FLAG_EN is defined.
- Acceptance at edge k → busy_o=1 after edge k. The RUN edges are k+1 through k+WIDTH. res_valid_o=1 after edge k+WIDTH.
- Latency is WIDTH cycles from acceptance to result valid.
- Result consumed at edge m → req_ready_o=1 after edge m. The earliest next acceptance is edge m+1.
- Back-to-back throughput is one operation per WIDTH+2 cycles, with res_ready_i tied high.
- rst_i and req_valid_i high on the same edge: reset wins and nothing is accepted.
- rst_i and res_ready_i high in DONE on the same edge: go to IDLE with outputs cleared.

## Configuration
- ZERO_FLAG_EN:
  - Defined: port zero_o exists. It is registered and updated on the last RUN edge as (final diff == 0), and is valid with res_valid_o.
  - Not defined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- WIDTH=8, a=0x5A, b=0x3C → after 8 cycles res_valid_o=1, diff_o=0x1E, borrow_o=0, zero_o=0.
- a=0x00, b=0x01 → diff_o=0xFF, borrow_o=1. Then a=0xFF, b=0xFF → diff_o=0x00, borrow_o=0, zero_o=1.
- Backpressure: res_ready_i held 0 for 5 cycles in DONE → outputs stable, req_ready_o=0, a new req_valid_i is not accepted. Raise res_ready_i → IDLE on the next edge.
- rst_i pulsed for one cycle at RUN cycle 3 → next cycle in IDLE, req_ready_o=1, res_valid_o=0. A fresh request a=0x10, b=0x01 then yields 0x0F with no corruption from the aborted operation.
- req_valid_i changes a_i/b_i during RUN → the result reflects only the operands sampled at acceptance.
- Random sweep of 1000 pairs at WIDTH=8 and WIDTH=3, with res_ready_i tied high → each diff_o/borrow_o matches a reference model. Measured spacing between results is WIDTH+2 cycles.
